// File: rtl/pcpi_muldiv.sv
// PCPI co-processor for the M-extension multiply/divide group: a shift-add
// multiplier retiring MUL_BITS bits per cycle and an optional restoring divider.
module pcpi_muldiv #(
  parameter int XLEN       = 32,
  parameter int MUL_BITS   = 4,
  parameter int ENABLE_DIV = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            pcpi_valid,
  input  logic [31:0]     pcpi_insn,
  input  logic [XLEN-1:0] pcpi_rs1,
  input  logic [XLEN-1:0] pcpi_rs2,
  output logic            pcpi_wr,
  output logic [XLEN-1:0] pcpi_rd,
  output logic            pcpi_wait,
  output logic            pcpi_ready
);
  localparam int MUL_STEPS = XLEN / MUL_BITS;
  localparam int CW        = $clog2(XLEN + 2);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_DONE = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [1:0]        r_f3;
  logic [2*XLEN-1:0] r_acc, r_mcand, w_pp, w_acc_next, w_acc_init, w_mcand_init;
  logic [XLEN-1:0]   r_mplier, r_quot, r_rem, r_div, r_result;
  logic              r_neg_q, r_neg_r;
  logic              w_match, w_accept, w_rs1_signed, w_rs2_signed, w_div_signed;
  logic              w_unused_insn, w_ge;
  logic [XLEN-1:0]   w_mul_res, w_abs1, w_abs2, w_q_fix, w_r_fix;
  logic [XLEN:0]     w_shift, w_diff;

  assign w_match = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001) &&
                   (!pcpi_insn[14] || (ENABLE_DIV != 0));
  assign w_accept      = (r_state == S_IDLE) && pcpi_valid && w_match;
  assign w_unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};
  assign w_rs1_signed  = (pcpi_insn[13:12] != 2'b11);
  assign w_rs2_signed  = !pcpi_insn[13];
  assign w_div_signed  = !pcpi_insn[12];

  // Only XLEN multiplier bits are iterated, so a negative signed rs2 is
  // compensated up front by pre-loading -(rs1 << XLEN) into the accumulator.
  assign w_acc_init   = (w_rs2_signed && pcpi_rs2[XLEN-1]) ?
                        ({(2*XLEN){1'b0}} - {pcpi_rs1, {XLEN{1'b0}}}) : {(2*XLEN){1'b0}};
  assign w_mcand_init = {{XLEN{w_rs1_signed & pcpi_rs1[XLEN-1]}}, pcpi_rs1};

  always_comb begin
    w_pp = {(2*XLEN){1'b0}};
    for (int j = 0; j < MUL_BITS; j++) begin
      w_pp = w_pp + ((r_mcand << j) & {(2*XLEN){r_mplier[j]}});
    end
  end

  assign w_acc_next = r_acc + w_pp;
  assign w_mul_res  = (r_f3 == 2'b00) ? w_acc_next[XLEN-1:0] : w_acc_next[2*XLEN-1:XLEN];

  assign w_abs1  = (w_div_signed && pcpi_rs1[XLEN-1]) ? ({XLEN{1'b0}} - pcpi_rs1) : pcpi_rs1;
  assign w_abs2  = (w_div_signed && pcpi_rs2[XLEN-1]) ? ({XLEN{1'b0}} - pcpi_rs2) : pcpi_rs2;
  assign w_shift = {r_rem, r_quot[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, r_div});
  assign w_diff  = w_shift - {1'b0, r_div};
  assign w_q_fix = r_neg_q ? ({XLEN{1'b0}} - r_quot) : r_quot;
  assign w_r_fix = r_neg_r ? ({XLEN{1'b0}} - r_rem) : r_rem;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = pcpi_insn[14] ? S_DIV : S_MUL;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_MUL, S_DIV: begin
        if (!pcpi_valid) begin
          w_next = S_IDLE;
        end else if (r_cnt == {CW{1'b0}}) begin
          w_next = S_DONE;
        end else begin
          w_next = r_state;
        end
      end
      S_DONE: w_next = S_HOLD;
      S_HOLD: begin
        if (!pcpi_valid) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_HOLD;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    pcpi_wait  = 1'b0;
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    pcpi_rd    = {XLEN{1'b0}};
    case (r_state)
      S_MUL, S_DIV: pcpi_wait = 1'b1;
      S_DONE: begin
        pcpi_ready = 1'b1;
        pcpi_wr    = 1'b1;
        pcpi_rd    = r_result;
      end
      default: pcpi_wait = 1'b0;
    endcase
  end

  // In DIV the counter's final zero step is the sign-fixup edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt    <= {CW{1'b0}};
      r_f3     <= 2'b00;
      r_acc    <= {(2*XLEN){1'b0}};
      r_mcand  <= {(2*XLEN){1'b0}};
      r_mplier <= {XLEN{1'b0}};
      r_quot   <= {XLEN{1'b0}};
      r_rem    <= {XLEN{1'b0}};
      r_div    <= {XLEN{1'b0}};
      r_result <= {XLEN{1'b0}};
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_f3     <= pcpi_insn[13:12];
            r_cnt    <= pcpi_insn[14] ? CW'(XLEN) : CW'(MUL_STEPS - 1);
            r_acc    <= w_acc_init;
            r_mcand  <= w_mcand_init;
            r_mplier <= pcpi_rs2;
            r_quot   <= w_abs1;
            r_div    <= w_abs2;
            r_rem    <= {XLEN{1'b0}};
            r_neg_q  <= w_div_signed && (pcpi_rs1[XLEN-1] ^ pcpi_rs2[XLEN-1]) &&
                        (pcpi_rs2 != {XLEN{1'b0}});
            r_neg_r  <= w_div_signed && pcpi_rs1[XLEN-1];
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << MUL_BITS;
          r_mplier <= r_mplier >> MUL_BITS;
          r_cnt    <= r_cnt - CW'(1);
          if (r_cnt == {CW{1'b0}}) begin
            r_result <= w_mul_res;
          end
        end
        S_DIV: begin
          if (r_cnt != {CW{1'b0}}) begin
            r_rem  <= w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
            r_quot <= {r_quot[XLEN-2:0], w_ge};
            r_cnt  <= r_cnt - CW'(1);
          end else begin
            r_result <= r_f3[1] ? w_r_fix : w_q_fix;
          end
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_pcpi_muldiv.sv
// Randomised and directed bench for pcpi_muldiv across four configurations,
// checked against an arithmetic reference model.
module tb_pcpi_muldiv;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, valid;
  logic [31:0] insn;
  logic [63:0] rs1, rs2;
  int          total = 0;
  int          bad = 0;
  int          sel = 0;

  logic        m_wr, m_wait, m_ready, b_wr, b_wait, b_ready;
  logic        n_wr, n_wait, n_ready, x_wr, x_wait, x_ready;
  logic [31:0] m_rd, b_rd, n_rd;
  logic [63:0] x_rd;
  logic        o_wr, o_wait, o_ready;
  logic [63:0] o_rd;

  pcpi_muldiv #(.XLEN(32), .MUL_BITS(4), .ENABLE_DIV(1)) u_main (
    .clk(clk), .resetn(resetn), .pcpi_valid(valid), .pcpi_insn(insn),
    .pcpi_rs1(rs1[31:0]), .pcpi_rs2(rs2[31:0]), .pcpi_wr(m_wr), .pcpi_rd(m_rd),
    .pcpi_wait(m_wait), .pcpi_ready(m_ready));
  pcpi_muldiv #(.XLEN(32), .MUL_BITS(1), .ENABLE_DIV(1)) u_mb1 (
    .clk(clk), .resetn(resetn), .pcpi_valid(valid), .pcpi_insn(insn),
    .pcpi_rs1(rs1[31:0]), .pcpi_rs2(rs2[31:0]), .pcpi_wr(b_wr), .pcpi_rd(b_rd),
    .pcpi_wait(b_wait), .pcpi_ready(b_ready));
  pcpi_muldiv #(.XLEN(64), .MUL_BITS(8), .ENABLE_DIV(1)) u_x64 (
    .clk(clk), .resetn(resetn), .pcpi_valid(valid), .pcpi_insn(insn),
    .pcpi_rs1(rs1), .pcpi_rs2(rs2), .pcpi_wr(x_wr), .pcpi_rd(x_rd),
    .pcpi_wait(x_wait), .pcpi_ready(x_ready));
  pcpi_muldiv #(.XLEN(32), .MUL_BITS(4), .ENABLE_DIV(0)) u_nodiv (
    .clk(clk), .resetn(resetn), .pcpi_valid(valid), .pcpi_insn(insn),
    .pcpi_rs1(rs1[31:0]), .pcpi_rs2(rs2[31:0]), .pcpi_wr(n_wr), .pcpi_rd(n_rd),
    .pcpi_wait(n_wait), .pcpi_ready(n_ready));

  always_comb begin
    case (sel)
      1: begin o_wr = b_wr; o_wait = b_wait; o_ready = b_ready; o_rd = {32'd0, b_rd}; end
      2: begin o_wr = x_wr; o_wait = x_wait; o_ready = x_ready; o_rd = x_rd; end
      3: begin o_wr = n_wr; o_wait = n_wait; o_ready = n_ready; o_rd = {32'd0, n_rd}; end
      default: begin o_wr = m_wr; o_wait = m_wait; o_ready = m_ready; o_rd = {32'd0, m_rd}; end
    endcase
  end

  function automatic logic [31:0] mk_insn(input logic [2:0] f3);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  // Reference: exact wide-integer arithmetic, truncated to xl bits.
  function automatic logic [63:0] ref_result(input int xl, input logic [2:0] f3,
                                             input logic [63:0] a, input logic [63:0] b);
    logic signed [129:0] sa, sb, ua, ub, p;
    logic [63:0] mask, r;
    mask = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    ua = {66'd0, a & mask};
    ub = {66'd0, b & mask};
    sa = (xl == 32) ? {{98{a[31]}}, a[31:0]} : {{66{a[63]}}, a};
    sb = (xl == 32) ? {{98{b[31]}}, b[31:0]} : {{66{b[63]}}, b};
    r = 64'd0;
    case (f3)
      3'd0: begin p = sa * sb; r = p[63:0]; end
      3'd1: begin p = (sa * sb) >>> xl; r = p[63:0]; end
      3'd2: begin p = (sa * ub) >>> xl; r = p[63:0]; end
      3'd3: begin p = (ua * ub) >>> xl; r = p[63:0]; end
      3'd4: begin if (ub == 130'd0) r = '1; else begin p = sa / sb; r = p[63:0]; end end
      3'd5: begin if (ub == 130'd0) r = '1; else begin p = ua / ub; r = p[63:0]; end end
      3'd6: begin if (ub == 130'd0) r = a; else begin p = sa % sb; r = p[63:0]; end end
      default: begin if (ub == 130'd0) r = a; else begin p = ua % ub; r = p[63:0]; end end
    endcase
    return r & mask;
  endfunction

  task automatic run_op(input int which, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int extra,
                        input string name);
    int xl, mb, lat, n;
    bit seen;
    xl  = (which == 2) ? 64 : 32;
    mb  = (which == 1) ? 1 : ((which == 2) ? 8 : 4);
    lat = f3[2] ? xl + 2 : xl / mb + 1;
    sel = which;
    @(negedge clk);
    valid = 1'b1; insn = mk_insn(f3); rs1 = a; rs2 = b;
    @(posedge clk); #1;
    total++;
    if (o_wait !== 1'b1) begin bad++; $display("FAIL %s wait_after_accept got=%b want=1", name, o_wait); end
    rs1 = {$urandom, $urandom}; rs2 = {$urandom, $urandom}; insn = mk_insn(f3 ^ 3'd1);
    n = 1; seen = 1'b0;
    while (!seen && n < lat + 8) begin
      @(posedge clk); #1; n++;
      if (o_ready === 1'b1) begin
        seen = 1'b1;
      end else begin
        total++;
        if (o_wait !== 1'b1 || o_wr !== 1'b0 || o_rd !== 64'd0) begin
          bad++; $display("FAIL %s busy cycle %0d wait=%b wr=%b rd=%h want wait=1 wr=0 rd=0", name, n, o_wait, o_wr, o_rd);
        end
      end
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL %s timeout no ready within %0d edges, want %0d", name, n, lat);
    end else begin
      total++;
      if (n != lat) begin bad++; $display("FAIL %s latency got=%0d want=%0d", name, n, lat); end
      total++;
      if (o_rd !== exp) begin bad++; $display("FAIL %s result got=%h want=%h", name, o_rd, exp); end
      total++;
      if (o_wr !== 1'b1 || o_wait !== 1'b0) begin
        bad++; $display("FAIL %s strobe wr=%b wait=%b want wr=1 wait=0", name, o_wr, o_wait);
      end
    end
    for (int k = 0; k < extra; k++) begin
      @(posedge clk); #1;
      total++;
      if (o_ready !== 1'b0 || o_wr !== 1'b0 || o_rd !== 64'd0 || o_wait !== 1'b0) begin
        bad++; $display("FAIL %s after_ready ready=%b wr=%b wait=%b rd=%h want all 0", name, o_ready, o_wr, o_wait, o_rd);
      end
    end
    @(negedge clk); valid = 1'b0; insn = 32'd0;
    @(posedge clk); @(posedge clk); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; valid = 1'b1; insn = mk_insn(3'd0); rs1 = 64'd3; rs2 = 64'd7;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({m_wr, m_wait, m_ready} !== 3'b000 || m_rd !== 32'd0) begin
      bad++; $display("FAIL reset_main wr/wait/ready=%b%b%b rd=%h want 0", m_wr, m_wait, m_ready, m_rd);
    end
    total++;
    if ({b_wr, b_wait, b_ready, n_wr, n_wait, n_ready} !== 6'd0 || b_rd !== 32'd0 || n_rd !== 32'd0) begin
      bad++; $display("FAIL reset_32b_cfgs outputs not 0 b_rd=%h n_rd=%h", b_rd, n_rd);
    end
    total++;
    if ({x_wr, x_wait, x_ready} !== 3'b000 || x_rd !== 64'd0) begin
      bad++; $display("FAIL reset_x64 wr/wait/ready=%b%b%b rd=%h want 0", x_wr, x_wait, x_ready, x_rd);
    end
    @(negedge clk); valid = 1'b0; insn = 32'd0; resetn = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_directed();
    run_op(0, 3'd0, 64'd3,          64'd7,          64'd21,         1, "mul_3x7");
    run_op(0, 3'd1, 64'hFFFFFFF6,   64'hFFFFFFFC,   64'd0,          2, "mulh_n10xn4");
    run_op(0, 3'd2, 64'hFFFFFFF6,   64'd4,          64'hFFFFFFFF,   1, "mulhsu_n10x4");
    run_op(0, 3'd3, 64'hFFFFFFFF,   64'hFFFFFFFF,   64'hFFFFFFFE,   1, "mulhu_max");
    run_op(0, 3'd0, 64'hFFFFFFFD,   64'd7,          64'hFFFFFFEB,   1, "mul_n3x7");
    run_op(0, 3'd4, 64'hFFFFFFF9,   64'd2,          64'hFFFFFFFD,   1, "div_n7_2");
    run_op(0, 3'd6, 64'hFFFFFFF9,   64'd2,          64'hFFFFFFFF,   2, "rem_n7_2");
    run_op(0, 3'd5, 64'd100,        64'd7,          64'd14,         1, "divu_100_7");
    run_op(0, 3'd7, 64'd100,        64'd7,          64'd2,          1, "remu_100_7");
    run_op(0, 3'd4, 64'd5,          64'd0,          64'hFFFFFFFF,   1, "div_by_zero");
    run_op(0, 3'd7, 64'd5,          64'd0,          64'd5,          1, "remu_by_zero");
    run_op(0, 3'd4, 64'h80000000,   64'hFFFFFFFF,   64'h80000000,   1, "div_overflow");
    run_op(0, 3'd6, 64'h80000000,   64'hFFFFFFFF,   64'd0,          1, "rem_overflow");
  endtask

  task automatic test_random(input int which, input int count, input bit with_div);
    logic [2:0]  f3;
    logic [63:0] a, b, mask, minv;
    int xl;
    xl   = (which == 2) ? 64 : 32;
    mask = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    minv = (xl == 32) ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
    for (int i = 0; i < count; i++) begin
      f3 = 3'($urandom_range(0, with_div ? 7 : 3));
      a  = {$urandom, $urandom} & mask;
      b  = {$urandom, $urandom} & mask;
      case ($urandom_range(0, 7))
        0: b = 64'd0;
        1: b = mask;
        2: begin a = minv; b = mask; end
        3: b = b >> $urandom_range(1, xl - 1);
        default: a = a;
      endcase
      run_op(which, f3, a, b, ref_result(xl, f3, a, b), 1 + (i % 2), "random");
    end
  endtask

  task automatic test_abort();
    bit stray;
    sel = 0;
    @(negedge clk); valid = 1'b1; insn = mk_insn(3'd0); rs1 = 64'd9; rs2 = 64'd11;
    repeat (3) @(posedge clk);
    @(negedge clk); valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (m_wait !== 1'b0 || m_ready !== 1'b0) begin
      bad++; $display("FAIL abort_wait_drop wait=%b ready=%b want 0 0", m_wait, m_ready);
    end
    stray = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (m_ready !== 1'b0 || m_wr !== 1'b0) stray = 1'b1; end
    total++;
    if (stray) begin bad++; $display("FAIL abort_no_ready got ready after abort want none"); end
    run_op(0, 3'd0, 64'd9, 64'd11, 64'd99, 1, "reissue_after_abort");
  endtask

  task automatic test_reset_mid_div();
    bit stray;
    sel = 0;
    @(negedge clk); valid = 1'b1; insn = mk_insn(3'd5); rs1 = 64'd1000; rs2 = 64'd3;
    repeat (11) @(posedge clk);
    @(negedge clk); resetn = 1'b0; valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({m_wr, m_wait, m_ready} !== 3'b000 || m_rd !== 32'd0) begin
      bad++; $display("FAIL reset_mid_div wr/wait/ready=%b%b%b rd=%h want 0", m_wr, m_wait, m_ready, m_rd);
    end
    @(negedge clk); resetn = 1'b1;
    stray = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (m_ready !== 1'b0 || m_wait !== 1'b0) stray = 1'b1; end
    total++;
    if (stray) begin bad++; $display("FAIL reset_mid_div_residue got activity after reset want none"); end
    run_op(0, 3'd5, 64'd1000, 64'd3, 64'd333, 1, "reissue_after_reset");
  endtask

  task automatic test_no_claim();
    bit act_n, act_m;
    sel = 3;
    @(negedge clk); valid = 1'b1; insn = mk_insn(3'd4); rs1 = 64'd50; rs2 = 64'd5;
    act_n = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (n_wait !== 1'b0 || n_ready !== 1'b0) act_n = 1'b1; end
    total++;
    if (act_n) begin bad++; $display("FAIL nodiv_claimed got wait/ready with ENABLE_DIV=0 want none"); end
    @(negedge clk); valid = 1'b0;
    repeat (2) @(posedge clk);
    sel = 0;
    @(negedge clk); valid = 1'b1; insn = mk_insn(3'd0) ^ 32'h0000_0040; rs1 = 64'd2; rs2 = 64'd2;
    act_m = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (m_wait !== 1'b0 || m_ready !== 1'b0 || m_rd !== 32'd0) act_m = 1'b1; end
    total++;
    if (act_m) begin bad++; $display("FAIL nonmatch_claimed got activity for wrong opcode want none"); end
    @(negedge clk); valid = 1'b0; insn = 32'd0;
    repeat (2) @(posedge clk);
    run_op(3, 3'd0, 64'd6, 64'd7, 64'd42, 1, "nodiv_mul");
  endtask

  task automatic test_configs();
    run_op(1, 3'd0, 64'd3, 64'd7, 64'd21, 1, "mb1_mul_3x7");
    test_random(1, 4, 1'b1);
    run_op(2, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFE, 1, "x64_mulhu_max");
    test_random(2, 8, 1'b1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; valid = 1'b0; insn = 32'd0; rs1 = 64'd0; rs2 = 64'd0;
    test_reset();
    test_directed();
    test_random(0, 40, 1'b1);
    test_abort();
    test_reset_mid_div();
    test_no_claim();
    test_configs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pcpi_muldiv.md
Name: pcpi_muldiv

Overview:
- Parametrised PCPI co-processor executing the RV32M/RV64M-style multiply and divide group.
- Covers MUL, MULH, MULHSU, MULHU, plus optional DIV, DIVU, REM, REMU.
- Successor to the fixed-width serial multiplier: configurable data width, configurable multiply bits-per-cycle, optional divider, abort on valid drop.
- Sits beside the core on the PCPI bus; the core stalls on pcpi_wait until the pcpi_ready/pcpi_wr pulse.

Parameters:
- XLEN, 32, operand and result width; legal values 32 and 64.
- MUL_BITS, 4, multiplier bits retired per cycle; legal values 1, 2, 4, 8; must divide XLEN.
- ENABLE_DIV, 1, 1 = claim and execute funct3[2]=1 ops; 0 = ignore them.

Ports:
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  synchronous active-low reset
- pcpi_valid  in  1  core presents instruction
- pcpi_insn  in  32  instruction word
- pcpi_rs1  in  XLEN  operand 1
- pcpi_rs2  in  XLEN  operand 2
- pcpi_wr  out  1  result write enable, pulses with pcpi_ready
- pcpi_rd  out  XLEN  result
- pcpi_wait  out  1  instruction claimed, busy
- pcpi_ready  out  1  one-cycle completion strobe

Behaviour:
- Reset: one clock; the reset is synchronous and active-low on resetn, sampled at the clk rising edge. While low, state goes to IDLE and all outputs are 0 (pcpi_rd = 0). Reset mid-operation discards the operation and issues no ready.
- Match: opcode insn[6:0]=0110011 and funct7 insn[31:25]=0000001; funct3 = insn[14:12]. funct3[2]=1 matches only if ENABLE_DIV=1.
- A non-matching instruction leaves all outputs 0 (the core times out and traps).
- States: IDLE, MUL, DIV, DONE, HOLD.
- IDLE: at the edge with pcpi_valid=1 and a match, latch rs1, rs2 and funct3. Go to MUL (funct3[2]=0) or DIV (funct3[2]=1). pcpi_wait is registered and goes to 1 after this edge.
- MUL: operands extended to 2*XLEN. rs1 is signed for 000, 001, 010; rs2 is signed for 000, 001; otherwise zero-extended. Each cycle retires MUL_BITS multiplier bits via shift-add.
  - After XLEN/MUL_BITS edges in MUL, go to DONE.
  - Result: funct3 000 = low XLEN bits; 001, 010, 011 = high XLEN bits.
- DIV: restoring divider, 1 quotient bit per cycle on magnitudes, XLEN edges, then one sign-fixup edge, then DONE.
  - Signed ops: quotient is negative iff the operand signs differ and the divisor is nonzero; remainder takes the dividend's sign.
  - Divide by zero: DIV/DIVU = all ones; REM/REMU = rs1.
  - Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1): DIV = rs1, REM = 0.
  - Special cases keep the full fixed latency.
- Latency, counted from the accept edge: ready is high in the cycle after edge number XLEN/MUL_BITS+1 for multiply, XLEN+2 for divide.
- DONE: a single cycle with pcpi_ready=1, pcpi_wr=1, pcpi_wait=0, pcpi_rd=result. Next edge goes to HOLD. pcpi_rd returns to 0 outside DONE.
- HOLD: no new accept until pcpi_valid is sampled 0, then go to IDLE. This prevents double execution when the core drops valid one cycle late.
- Abort: pcpi_valid sampled 0 while in MUL or DIV returns to IDLE with no ready or wr; pcpi_wait drops after that edge.
- Back-to-back: the earliest next accept is the edge after HOLD observes valid low.
- Operand changes on rs1/rs2/insn after accept have no effect.

Test Plan:
- XLEN=32, MUL_BITS=4: MUL rs1=3, rs2=7 -> pcpi_rd=21, pcpi_wr=pcpi_ready=1 for exactly one cycle, 9 cycles after accept; pcpi_wait high for the 8 cycles before.
- Sign modes: MULH -10×-4 -> 0; MULHSU -10×4 -> 0xFFFFFFFF; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MUL -3×7 -> 0xFFFFFFEB.
- Divide: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each ready 34 cycles after accept.
- Corners: DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM 0x80000000/-1 -> 0.
- Control:
  - Drop pcpi_valid 3 cycles into a MUL -> no ready, wait low next cycle.
  - Reissue -> correct result.
  - resetn low mid-DIV -> all outputs 0.
  - Hold valid high 1 extra cycle after ready -> no second ready.
- Configs: ENABLE_DIV=0 with DIV -> wait/ready never assert. MUL_BITS=1 MUL -> ready 33 cycles after accept. XLEN=64, MUL_BITS=8 MULHU (2^64-1)^2 -> 0xFFFFFFFFFFFFFFFE, ready 9 cycles after accept.
